// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and ALU function codes
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [REG_W-1:0] LINK_REG = 5'd31;

    // Only the low three bits select the operation, except for the right shifts
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

endpackage

// File: rtl/exe_stage_alu.sv
// rtl/exe_stage_alu.sv - combinational ALU/shifter for the execute stage
module alu
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        aluc,
    output logic [DATA_W-1:0] r
);

    logic [4:0] shamt;

    assign shamt = a[4:0];

    always_comb begin
        r = '0;
        case (aluc[2:0])
            ALUC_ADD[2:0]: r = a + b;
            ALUC_SUB[2:0]: r = a - b;
            ALUC_AND[2:0]: r = a & b;
            ALUC_OR[2:0]:  r = a | b;
            ALUC_XOR[2:0]: r = a ^ b;
            ALUC_LUI[2:0]: r = {b[15:0], 16'h0000};
            ALUC_SLL[2:0]: r = b << shamt;
            // bit 3 separates arithmetic from logical right shift
            ALUC_SRL[2:0]: r = aluc[3] ? $unsigned($signed(b) >>> shamt) : (b >> shamt);
            default:       r = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - MIPS execute stage with EXE/MEM pipeline register
module exe_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ea,
    input  logic [DATA_W-1:0] eb,
    input  logic [DATA_W-1:0] eimm,
    input  logic [DATA_W-1:0] epc4,
    input  logic [REG_W-1:0]  ern,
    input  logic [3:0]        ealuc,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic              ewmem,
    input  logic              ealuimm,
    input  logic              eshift,
    input  logic              ejal,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] malu,
    output logic [DATA_W-1:0] mb,
    output logic [REG_W-1:0]  mrn,
    output logic              mwreg,
    output logic              mm2reg,
    output logic              mwmem,
    output logic              mvalid,
    output logic [DATA_W-1:0] ealu_fwd
);

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_r;
    logic [DATA_W-1:0] result;

    assign alu_a = eshift  ? {27'b0, eimm[10:6]} : ea;
    assign alu_b = ealuimm ? eimm : eb;

    alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .aluc (ealuc),
        .r    (alu_r)
    );

    // jal links to the instruction after its delay slot
    assign result   = ejal ? (epc4 + 32'd4) : alu_r;
    assign ealu_fwd = result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            malu   <= '0;
            mb     <= '0;
            mrn    <= '0;
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            mvalid <= 1'b0;
        end else if (flush) begin
            malu   <= '0;
            mb     <= '0;
            mrn    <= '0;
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            mvalid <= 1'b0;
        end else if (!stall) begin
            malu   <= result;
            mb     <= eb;
            mrn    <= ern;
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            mvalid <= ewreg | ewmem | ejal;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - self-checking bench for exe_stage with a behavioural reference model
module tb_exe_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] ea, eb, eimm, epc4;
    logic [4:0]  ern;
    logic [3:0]  ealuc;
    logic        ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
    logic        stall, flush;
    logic [31:0] malu, mb, ealu_fwd;
    logic [4:0]  mrn;
    logic        mwreg, mm2reg, mwmem, mvalid;

    int checks = 0;
    int errors = 0;

    logic [31:0] x_malu, x_mb;
    logic [4:0]  x_mrn;
    logic        x_mwreg, x_mm2reg, x_mwmem, x_mvalid;

    exe_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ea       (ea),
        .eb       (eb),
        .eimm     (eimm),
        .epc4     (epc4),
        .ern      (ern),
        .ealuc    (ealuc),
        .ewreg    (ewreg),
        .em2reg   (em2reg),
        .ewmem    (ewmem),
        .ealuimm  (ealuimm),
        .eshift   (eshift),
        .ejal     (ejal),
        .stall    (stall),
        .flush    (flush),
        .malu     (malu),
        .mb       (mb),
        .mrn      (mrn),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mwmem    (mwmem),
        .mvalid   (mvalid),
        .ealu_fwd (ealu_fwd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_result();
        logic [31:0] a, b;
        int unsigned sh;
        a  = eshift ? 32'(eimm[10:6]) : ea;
        b  = ealuimm ? eimm : eb;
        sh = int'(a[4:0]);
        if (ejal) return epc4 + 32'd4;
        casez (ealuc)
            4'b?000: return a + b;
            4'b?100: return a - b;
            4'b?001: return a & b;
            4'b?101: return a | b;
            4'b?010: return a ^ b;
            4'b?110: return b * 32'd65536;
            4'b0011: return b << sh;
            4'b0111: return b >> sh;
            4'b1111: return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    task automatic clear_model();
        x_malu = '0; x_mb = '0; x_mrn = '0;
        x_mwreg = 1'b0; x_mm2reg = 1'b0; x_mwmem = 1'b0; x_mvalid = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_malu"},   malu,           x_malu);
        chk({tag, "_mb"},     mb,             x_mb);
        chk({tag, "_mrn"},    32'(mrn),       32'(x_mrn));
        chk({tag, "_mwreg"},  32'(mwreg),     32'(x_mwreg));
        chk({tag, "_mm2reg"}, 32'(mm2reg),    32'(x_mm2reg));
        chk({tag, "_mwmem"},  32'(mwmem),     32'(x_mwmem));
        chk({tag, "_mvalid"}, 32'(mvalid),    32'(x_mvalid));
    endtask

    task automatic set_idle();
        ea = '0; eb = '0; eimm = '0; epc4 = '0; ern = '0; ealuc = '0;
        ewreg = 0; em2reg = 0; ewmem = 0; ealuimm = 0; eshift = 0; ejal = 0;
        stall = 0; flush = 0;
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge
    task automatic cycle(input string tag);
        logic [31:0] r;
        r = model_result();
        #1 chk({tag, "_fwd"}, ealu_fwd, r);
        @(posedge clk);
        if (flush) begin
            clear_model();
        end else if (!stall) begin
            x_malu = r; x_mb = eb; x_mrn = ern;
            x_mwreg = ewreg; x_mm2reg = em2reg; x_mwmem = ewmem;
            x_mvalid = ewreg | ewmem | ejal;
        end
        #1 check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        ea = $urandom; eb = $urandom; eimm = $urandom; epc4 = $urandom;
        ern = 5'($urandom_range(0, 31));
        ealuc = 4'($urandom_range(0, 15));
        if (ealuc == 4'b1011) ealuc = 4'b0011;
        ewreg = 1'($urandom); em2reg = 1'($urandom); ewmem = 1'($urandom);
        ealuimm = 1'($urandom); eshift = 1'($urandom); ejal = 1'($urandom_range(0, 5) == 0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        clear_model();
        #3 check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        ea = 32'd5; eb = 32'd7; ealuc = 4'b0000; ewreg = 1; ern = 5'd8;
        #1 chk("add_fwd_direct", ealu_fwd, 32'd12);
        cycle("add");
        chk("add_malu_direct", malu, 32'd12);
        chk("add_mrn_direct", 32'(mrn), 32'd8);

        set_idle();
        ea = 32'd3; eimm = 32'hFFFF_FFFF; ealuimm = 1; ealuc = 4'b0100; ewreg = 1;
        cycle("subi");
        chk("subi_malu_direct", malu, 32'd4);

        set_idle();
        eb = 32'h8000_0000; eimm = 32'h0000_0100; eshift = 1; ewreg = 1; ealuc = 4'b1111;
        cycle("sra");
        chk("sra_malu_direct", malu, 32'hF800_0000);
        ealuc = 4'b0111;
        cycle("srl");
        chk("srl_malu_direct", malu, 32'h0800_0000);
        ealuc = 4'b0011; eb = 32'd1;
        cycle("sll");
        chk("sll_malu_direct", malu, 32'h0000_0010);

        set_idle();
        epc4 = 32'h0040_0008; ejal = 1; ern = 5'd31; ewreg = 1;
        cycle("jal");
        chk("jal_malu_direct", malu, 32'h0040_000C);
        chk("jal_mrn_direct", 32'(mrn), 32'd31);

        set_idle();
        cycle("bubble");

        ea = 32'd100; eb = 32'd23; ealuc = 4'b0101; ewreg = 1; ern = 5'd4;
        cycle("pre_stall");
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            stall = 1; flush = 0;
            cycle("stall");
        end
        chk("stall_malu_direct", malu, 32'd119);
        randomize_inputs();
        stall = 1; flush = 1;
        cycle("stall_flush");
        chk("flush_mvalid_direct", 32'(mvalid), 32'd0);

        set_idle();
        ewmem = 1; eb = 32'hDEAD_BEEF; ea = 32'h10; eimm = 32'h4; ealuimm = 1;
        cycle("store");
        chk("store_mb_direct", mb, 32'hDEAD_BEEF);
        chk("store_mwmem_direct", 32'(mwmem), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        clear_model();
        #1 check_outputs("async_reset");
        rst_n = 1'b1;
        @(negedge clk);
        ea = 32'd9; eb = 32'd1; ealuc = 4'b0000; ewreg = 1; ern = 5'd2; ewmem = 0; ealuimm = 0;
        cycle("post_reset");

        for (int i = 0; i < 60; i++) begin
            randomize_inputs();
            stall = 1'($urandom_range(0, 3) == 0);
            flush = 1'($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
